// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and width default for the serial adder
//
// Purpose: state encoding for the serial_add_ctrl FSM and the default
// operand width. Optional feature macro used by the block: SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - 1-bit full adder built from two half-adder stages
//
// Ports:
//   a, b  in  1  addend bits
//   ci    in  1  carry in
//   s     out 1  sum bit
//   co    out 1  carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;
  assign s    = h1_s ^ ci;
  assign h2_c = h1_s & ci;
  assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder, LSB first, one shared full-adder cell
//
// Purpose: computes a + b + cin over WIDTH cycles using a single fa_cell and
// a carry flip-flop. Optional: SERIAL_ADD_OVF_EN adds a signed-overflow output.
//
// Parameter: WIDTH operand width, 2..32 (default from serial_add_pkg)
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous active-high reset
//   start  in  1      begin an addition (sampled only in IDLE)
//   a, b   in  WIDTH  operands, captured on accepted start
//   cin    in  1      carry in, captured on accepted start
//   busy   out 1      high while in RUN
//   done   out 1      one-cycle pulse, sum/cout valid from this cycle
//   sum    out WIDTH  registered result
//   cout   out 1      registered carry out
//   ovf    out 1      signed overflow (only with SERIAL_ADD_OVF_EN)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  // Sized to hold WIDTH so the counter never wraps during RUN.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s;
  logic             fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             cmsb_q;   // carry into bit WIDTH-1
`endif

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt_q == LAST_BIT) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
          if (cnt_q == LAST_BIT) cmsb_q <= carry_q;
`endif
        end
        DONE: begin
          sum  <= res_q;
          cout <= carry_q;
          done <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          ovf  <= cmsb_q ^ carry_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed scoreboard bench for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  // {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive a request at a negedge and push its reference result.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         o;
    a_i   = av;
    b_i   = bv;
    cin_i = cv;
    start = 1'b1;
    full  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    s     = full[W-1:0];
    o     = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
    exp_q.push_back({o, full[W], s});
  endtask

  // Follow the accepted request through RUN and DONE, then score the result.
  task automatic complete(input string tag, input bit hold_start);
    int           n;
    logic [W-1:0] held;
    logic [W+1:0] e;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    a_i   = W'($urandom);
    b_i   = W'($urandom);
    cin_i = 1'($urandom);
    held  = sum;
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 5) chk({tag, "_sum_hold"}, 32'(sum), 32'(held));
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(W));
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
    end
  endtask

  initial begin
    int seen_done;
    reset = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    cin_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    launch(8'h35, 8'h4A, 1'b0); complete("op35_4a", 0);
    launch(8'hFF, 8'h01, 1'b0); complete("opff_01", 0);
    launch(8'hFF, 8'hFF, 1'b1); complete("opff_ff_c", 0);
    launch(8'h00, 8'h00, 1'b0); complete("op00_00", 0);
    for (int i = 0; i < 4; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom));
      complete("oprand", 0);
    end

    // start held high: second op must be accepted right after the done cycle
    launch(8'h12, 8'h34, 1'b1); complete("hold1", 1);
    launch(8'hA0, 8'h71, 1'b0);
    @(negedge clk);
    chk("hold2_started", 32'(busy), 32'd1);
    start = 1'b0;
    n_wait_done("hold2");

    // reset during RUN cycle 4
    @(negedge clk);
    a_i = 8'h55; b_i = 8'h66; cin_i = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum",  32'(sum),  32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);

    launch(8'h7F, 8'h01, 1'b0); complete("op7f_01", 0);
    launch(8'h80, 8'h80, 1'b0); complete("op80_80", 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Remaining tail of an op already one cycle into RUN.
  task automatic n_wait_done(input string tag);
    int           n;
    logic [W+1:0] e;
    n = 1;
    while (busy && n < 20) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(W));
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
    end
  endtask

endmodule
